// File: rtl/mem_access_unit_if.sv
// Bundle of core request/response and data-memory port signals for mem_access_unit.
// slave: the unit itself; master: the core plus the memory it drives.
interface mem_access_unit_if;
  // Core side: req/we/funct3/addr/wdata are sampled only while the unit is idle.
  // done pulses for exactly one cycle per accepted request; err and rdata are
  // meaningful while done is high. The core must not expect any back-pressure:
  // a req seen while busy is simply ignored.
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  // Memory side: readData is combinational from memAdr; memWrite commits at the clock edge.
  logic        memWrite;
  logic [31:0] memAdr;
  logic [31:0] writeData;
  logic [31:0] readData;

  modport slave (
    input  req, we, funct3, addr, wdata, readData,
    output rdata, busy, done, err, memWrite, memAdr, writeData
  );

  modport master (
    output req, we, funct3, addr, wdata, readData,
    input  rdata, busy, done, err, memWrite, memAdr, writeData
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store engine for a big-endian byte-addressed data memory (byte at memAdr = bits [31:24]).
// Optional build macro MEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses.
module mem_access_unit #(
  parameter int ADDR_W    = 16,
  parameter int LOAD_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_LOAD   = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_ST_WR  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'((LOAD_WAIT > 0) ? (LOAD_WAIT - 1) : 0);
  localparam bit         HAS_WAIT  = (LOAD_WAIT > 0);

  state_t      state;
  state_t      state_next;

  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [23:0] old_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [3:0]  wait_cnt;

  logic        illegal_f3;
  logic        misaligned;
  logic        reject;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic        unused_addr_bits;

  // Request screening happens on the raw bus so a rejected request goes straight to DONE.
  assign illegal_f3 = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                      (bus.funct3 == 3'b111) || (bus.funct3[2] && bus.we);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                      ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign reject = illegal_f3 || misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (bus.req) begin
          if (reject) begin
            state_next = S_DONE;
          end else if (!bus.we) begin
            state_next = HAS_WAIT ? S_WAIT : S_LOAD;
          end else if (bus.funct3 == 3'b010) begin
            state_next = S_ST_WR;
          end else begin
            state_next = HAS_WAIT ? S_WAIT : S_RMW_RD;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_next = we_q ? S_RMW_RD : S_LOAD;
        end
      end
      S_LOAD:   state_next = S_DONE;
      S_RMW_RD: state_next = S_RMW_WR;
      S_RMW_WR: state_next = S_DONE;
      S_ST_WR:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Byte/halfword lanes sit at the top of the word because the layout is big-endian.
  always_comb begin
    load_ext = bus.readData;
    case (f3_q)
      3'b000:  load_ext = {{24{bus.readData[31]}}, bus.readData[31:24]};
      3'b100:  load_ext = {24'h000000, bus.readData[31:24]};
      3'b001:  load_ext = {{16{bus.readData[31]}}, bus.readData[31:16]};
      3'b101:  load_ext = {16'h0000, bus.readData[31:16]};
      default: load_ext = bus.readData;
    endcase
  end

  always_comb begin
    merged = 32'h0;
    if (f3_q == 3'b000) begin
      merged = {wdata_q[7:0], old_q[23:0]};
    end else begin
      merged = {wdata_q[15:0], old_q[15:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      old_q    <= 24'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      wait_cnt <= 4'h0;
    end else begin
      if ((state == S_IDLE) && bus.req) begin
        we_q    <= bus.we;
        f3_q    <= bus.funct3;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        err_q   <= reject;
      end
      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 4'h1;
      end else begin
        wait_cnt <= 4'h0;
      end
      if (state == S_LOAD) begin
        rdata_q <= load_ext;
      end
      if (state == S_RMW_RD) begin
        old_q <= bus.readData[23:0];
      end
    end
  end

  // Write strobe and data are pure state decodes, so reset kills a pending write instantly.
  always_comb begin
    bus.writeData = 32'h0;
    case (state)
      S_RMW_WR: bus.writeData = merged;
      S_ST_WR:  bus.writeData = wdata_q;
      default:  bus.writeData = 32'h0;
    endcase
  end

  assign bus.memWrite = (state == S_RMW_WR) || (state == S_ST_WR);
  assign bus.memAdr   = 32'(addr_q[ADDR_W-1:0]);
  assign bus.rdata    = rdata_q;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.err      = (state == S_DONE) && err_q;
  assign dbg_state    = state;

  assign unused_addr_bits = ^addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a 64 KiB big-endian byte memory model.
// Builds with or without MEM_ALIGN_CHECK_EN; expectations follow the macro.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_mem = 1'b1;
  logic [2:0]  dbg_state;
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  mem [0:65535];
  logic [31:0] exp_q [$];
  logic [15:0] a0;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;

  assign a0 = bus.memAdr[15:0];
  assign bus.readData = {mem[a0], mem[a0 + 16'd1], mem[a0 + 16'd2], mem[a0 + 16'd3]};

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
      mem[16'h0100] <= 8'h80;
      mem[16'h0101] <= 8'h12;
      mem[16'h0102] <= 8'h34;
      mem[16'h0103] <= 8'h56;
      mem[16'h0104] <= 8'h9A;
    end else if (bus.memWrite === 1'b1) begin
      mem[a0]          <= bus.writeData[31:24];
      mem[a0 + 16'd1]  <= bus.writeData[23:16];
      mem[a0 + 16'd2]  <= bus.writeData[15:8];
      mem[a0 + 16'd3]  <= bus.writeData[7:0];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  // lat = cycles from the accepting edge to the done sample (-1 on timeout).
  task automatic run_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output int wr, output logic e);
    lat = -1;
    wr  = 0;
    e   = 1'bx;
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.funct3 = f; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      bus.req = 1'b0;
      if (bus.memWrite === 1'b1) wr++;
      if (bus.done === 1'b1) begin
        lat = i;
        e   = bus.err;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    init_mem = 1'b0;
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    tests++; if (bus.memWrite !== 1'b0) begin fails++; $display("FAIL reset_memwrite: got %b expected 0", bus.memWrite); end
    tests++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 00000000", bus.rdata); end
    tests++; if (bus.memAdr !== 32'h0) begin fails++; $display("FAIL reset_memadr: got %h expected 00000000", bus.memAdr); end
    tests++; if (bus.writeData !== 32'h0) begin fails++; $display("FAIL reset_writedata: got %h expected 00000000", bus.writeData); end
    tests++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    logic [2:0] f3s [5];
    int lat, wr;
    logic e;
    logic [31:0] exp;
    f3s = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    exp_q.push_back(32'hFFFFFF80);
    exp_q.push_back(32'h00000080);
    exp_q.push_back(32'hFFFF8012);
    exp_q.push_back(32'h00008012);
    exp_q.push_back(32'h80123456);
    for (int k = 0; k < 5; k++) begin
      run_req(1'b0, f3s[k], 32'h0000_0100, 32'h0, lat, wr, e);
      exp = exp_q.pop_front();
      tests++; if (bus.rdata !== exp) begin fails++; $display("FAIL load_rdata f3=%b: got %h expected %h", f3s[k], bus.rdata, exp); end
      tests++; if (lat != 2) begin fails++; $display("FAIL load_latency f3=%b: got %0d expected 2", f3s[k], lat); end
      tests++; if (wr != 0) begin fails++; $display("FAIL load_memwrite f3=%b: got %0d write cycles expected 0", f3s[k], wr); end
      tests++; if (e !== 1'b0) begin fails++; $display("FAIL load_err f3=%b: got %b expected 0", f3s[k], e); end
    end
  endtask

  // req held high: a new request is only accepted after DONE returns to IDLE.
  task automatic test_back_to_back();
    logic [7:0] mask;
    mask = 8'h00;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b100; bus.addr = 32'h0000_0104; bus.wdata = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mask[i] = (bus.done === 1'b1);
    end
    bus.req = 1'b0;
    tests++; if (mask !== 8'b1001_0010) begin fails++; $display("FAIL b2b_done_pattern: got %b expected 10010010", mask); end
    tests++; if (bus.rdata !== 32'h0000009A) begin fails++; $display("FAIL b2b_rdata: got %h expected 0000009a", bus.rdata); end
  endtask

  task automatic test_illegal_align();
    int lat, wr;
    logic e;
    run_req(1'b0, 3'b011, 32'h0000_0100, 32'h0, lat, wr, e);
    tests++; if (e !== 1'b1 || lat != 1) begin fails++; $display("FAIL illegal_f3_load: got err=%b lat=%0d expected err=1 lat=1", e, lat); end
    tests++; if (bus.rdata !== 32'h0000009A) begin fails++; $display("FAIL illegal_rdata_hold: got %h expected 0000009a", bus.rdata); end
    run_req(1'b1, 3'b100, 32'h0000_0100, 32'h0000_00FF, lat, wr, e);
    tests++; if (e !== 1'b1 || lat != 1 || wr != 0) begin fails++; $display("FAIL illegal_store_bu: got err=%b lat=%0d wr=%0d expected err=1 lat=1 wr=0", e, lat, wr); end
    run_req(1'b0, 3'b010, 32'h0000_0102, 32'h0, lat, wr, e);
`ifdef MEM_ALIGN_CHECK_EN
    tests++; if (e !== 1'b1 || lat != 1) begin fails++; $display("FAIL align_lw: got err=%b lat=%0d expected err=1 lat=1", e, lat); end
    tests++; if (bus.rdata !== 32'h0000009A) begin fails++; $display("FAIL align_lw_rdata: got %h expected 0000009a", bus.rdata); end
    run_req(1'b0, 3'b001, 32'h0000_0101, 32'h0, lat, wr, e);
    tests++; if (e !== 1'b1 || lat != 1) begin fails++; $display("FAIL align_lh: got err=%b lat=%0d expected err=1 lat=1", e, lat); end
    run_req(1'b1, 3'b010, 32'h0000_0101, 32'hDEADBEEF, lat, wr, e);
    tests++; if (e !== 1'b1 || wr != 0) begin fails++; $display("FAIL align_sw: got err=%b wr=%0d expected err=1 wr=0", e, wr); end
`else
    tests++; if (e !== 1'b0 || lat != 2) begin fails++; $display("FAIL unaligned_lw: got err=%b lat=%0d expected err=0 lat=2", e, lat); end
    tests++; if (bus.rdata !== 32'h34569A00) begin fails++; $display("FAIL unaligned_lw_rdata: got %h expected 34569a00", bus.rdata); end
    run_req(1'b0, 3'b001, 32'h0000_0101, 32'h0, lat, wr, e);
    tests++; if (bus.rdata !== 32'h00001234 || e !== 1'b0) begin fails++; $display("FAIL unaligned_lh: got %h err=%b expected 00001234 err=0", bus.rdata, e); end
`endif
  endtask

  task automatic test_reset_mid();
    int lat, wr;
    logic e;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b000; bus.addr = 32'h0000_0100; bus.wdata = 32'h1122_3344;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    tests++; if (dbg_state !== 3'd3) begin fails++; $display("FAIL mid_state_rmw_rd: got %0d expected 3", dbg_state); end
    rst_n = 1'b0;
    #1;
    tests++; if (bus.memWrite !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++; $display("FAIL mid_reset_outputs: got memWrite=%b busy=%b done=%b expected 0 0 0", bus.memWrite, bus.busy, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, lat, wr, e);
    tests++; if (bus.rdata !== 32'h80123456) begin fails++; $display("FAIL mid_reset_mem: got %h expected 80123456", bus.rdata); end
  endtask

  task automatic test_store_byte();
    int lat, wr;
    logic e;
    run_req(1'b1, 3'b000, 32'h0000_0101, 32'hAABBCCDD, lat, wr, e);
    tests++; if (lat != 3 || wr != 1 || e !== 1'b0) begin fails++; $display("FAIL sb_timing: got lat=%0d wr=%0d err=%b expected lat=3 wr=1 err=0", lat, wr, e); end
    tests++; if (bus.rdata !== 32'h80123456) begin fails++; $display("FAIL sb_rdata_hold: got %h expected 80123456", bus.rdata); end
    run_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, lat, wr, e);
    tests++; if (bus.rdata !== 32'h80DD3456) begin fails++; $display("FAIL sb_readback: got %h expected 80dd3456", bus.rdata); end
    run_req(1'b0, 3'b100, 32'h0000_0104, 32'h0, lat, wr, e);
    tests++; if (bus.rdata !== 32'h0000009A) begin fails++; $display("FAIL sb_neighbour: got %h expected 0000009a", bus.rdata); end
  endtask

  task automatic test_store_half_word();
    int lat, wr;
    logic e;
    run_req(1'b1, 3'b001, 32'h0000_0100, 32'h0000BEEF, lat, wr, e);
    tests++; if (lat != 3 || wr != 1 || e !== 1'b0) begin fails++; $display("FAIL sh_timing: got lat=%0d wr=%0d err=%b expected lat=3 wr=1 err=0", lat, wr, e); end
    run_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, lat, wr, e);
    tests++; if (bus.rdata !== 32'hBEEF3456) begin fails++; $display("FAIL sh_readback: got %h expected beef3456", bus.rdata); end
    run_req(1'b1, 3'b010, 32'h0001_0200, 32'hCAFEF00D, lat, wr, e);
    tests++; if (lat != 2 || wr != 1 || e !== 1'b0) begin fails++; $display("FAIL sw_timing: got lat=%0d wr=%0d err=%b expected lat=2 wr=1 err=0", lat, wr, e); end
    run_req(1'b0, 3'b010, 32'h0000_0200, 32'h0, lat, wr, e);
    tests++; if (bus.rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL sw_truncated_readback: got %h expected cafef00d", bus.rdata); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000; bus.addr = 32'h0; bus.wdata = 32'h0;
    test_reset();
    test_loads();
    test_back_to_back();
    test_illegal_align();
    test_reset_mid();
    test_store_byte();
    test_store_half_word();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
